// File: rtl/custom_busmatrix_pkg.sv
// Shared AHB bus-matrix definitions: transfer/burst encodings and burst length lookup.
// No logic of its own; imported by the arbiter and its burst tracker.
package custom_busmatrix_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // SEQ beats left after the NONSEQ before the last beat; undefined-length INCR
    // is treated as 4 beats so it can be re-arbitrated at that point.
    function automatic logic [3:0] burst_beats_remaining(input logic [2:0] hburst);
        logic [3:0] rem;
        case (hburst)
            HBURST_WRAP16, HBURST_INCR16: rem = 4'd14;
            HBURST_WRAP8,  HBURST_INCR8:  rem = 4'd6;
            HBURST_WRAP4,  HBURST_INCR4,
            HBURST_INCR:                  rem = 4'd2;
            default:                      rem = 4'd0;
        endcase
        return rem;
    endfunction

endpackage

// File: rtl/custom_busmatrix_wrr_arbiter_if.sv
// Request/burst/grant bundle between an output port's bus logic and its WRR arbiter.
// master drives requests and the owner's transfer signals; slave is the arbiter.
interface custom_busmatrix_wrr_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int WEIGHT_W  = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]          req_port;
    logic [NUM_PORTS*WEIGHT_W-1:0] weight;
    logic                          HREADYM;
    logic                          HSELM;
    logic [1:0]                    HTRANSM;
    logic [2:0]                    HBURSTM;
    logic                          HMASTLOCKM;
    logic [PORT_W-1:0]             addr_in_port;
    logic                          no_port;
    logic                          grant_change;

    modport master (
        output req_port, weight, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, grant_change
    );

    modport slave (
        input  req_port, weight, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, grant_change
    );
endinterface

// File: rtl/custom_busmatrix_burst_tracker.sv
// Tracks whether the current owner is inside a burst that must not be split.
// next_burst_hold is combinational from this cycle's inputs; state frozen while HREADYM=0.
module custom_busmatrix_burst_tracker
    import custom_busmatrix_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       HREADYM,
    output logic       next_burst_hold,
    output logic       burst_hold
);

    logic [3:0] remain_q, remain_nxt;
    logic       hold_q, hold_nxt;
    logic [1:0] early_q, early_nxt;

    always_comb begin
        remain_nxt = remain_q;
        hold_nxt   = hold_q;
        if (!HSELM || HTRANSM == HTRANS_IDLE) begin
            remain_nxt = 4'd0;
            hold_nxt   = 1'b0;
        end else begin
            case (HTRANSM)
                HTRANS_NONSEQ: begin
                    remain_nxt = burst_beats_remaining(HBURSTM);
                    // second back-to-back INCR already ran 4 beats: let others in
                    hold_nxt   = (HBURSTM != HBURST_SINGLE) &&
                                 !(HBURSTM == HBURST_INCR && early_q == 2'd1);
                end
                HTRANS_SEQ: begin
                    if (remain_q == 4'd0) hold_nxt = 1'b0;
                    else                  remain_nxt = remain_q - 4'd1;
                end
                default: begin
                end
            endcase
        end

        early_nxt = early_q;
        if (!hold_nxt)
            early_nxt = 2'd0;
        else if (HTRANSM == HTRANS_NONSEQ && hold_q)
            early_nxt = early_q + 2'd1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            remain_q <= 4'd0;
            hold_q   <= 1'b0;
            early_q  <= 2'd0;
        end else if (HREADYM) begin
            remain_q <= remain_nxt;
            hold_q   <= hold_nxt;
            early_q  <= early_nxt;
        end
    end

    assign next_burst_hold = hold_nxt;
    assign burst_hold      = hold_q;

endmodule

// File: rtl/custom_busmatrix_wrr_arbiter.sv
// Weighted round-robin owner selection for one bus-matrix output port.
// One-cycle registered grant; everything freezes while HREADYM=0.
module custom_busmatrix_wrr_arbiter
    import custom_busmatrix_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS),
    parameter int WEIGHT_W  = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    custom_busmatrix_wrr_arbiter_if.slave bus
);

    logic [PORT_W-1:0]   grant_q, grant_nxt;
    logic                no_port_q, no_port_nxt;
    logic                grant_change_q;
    logic [WEIGHT_W-1:0] credit_q   [NUM_PORTS];
    logic [WEIGHT_W-1:0] credit_nxt [NUM_PORTS];
    logic [WEIGHT_W-1:0] w_eff      [NUM_PORTS];
    logic [WEIGHT_W-1:0] owner_cred_nxt;
    logic                beat;
    logic                next_burst_hold;
    logic                burst_hold;
    logic                lo_vld, rr_vld;
    logic [PORT_W-1:0]   lo_idx, rr_idx;
    int                  pos;

    custom_busmatrix_burst_tracker u_burst (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .HSELM           (bus.HSELM),
        .HTRANSM         (bus.HTRANSM),
        .HBURSTM         (bus.HBURSTM),
        .HREADYM         (bus.HREADYM),
        .next_burst_hold (next_burst_hold),
        .burst_hold      (burst_hold)
    );

    // A zero weight still grants one beat per turn
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_eff[i] = (bus.weight[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                       WEIGHT_W'(1) : bus.weight[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    assign beat = !no_port_q && bus.HSELM &&
                  (bus.HTRANSM == HTRANS_NONSEQ || bus.HTRANSM == HTRANS_SEQ);
    assign owner_cred_nxt = (beat && credit_q[grant_q] != '0) ?
                            credit_q[grant_q] - WEIGHT_W'(1) : credit_q[grant_q];

    // Lowest-index requester, and first requester after the owner (owner excluded)
    always_comb begin
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.req_port[i]) begin
                lo_vld = 1'b1;
                lo_idx = PORT_W'(i);
            end
        end
        rr_vld = 1'b0;
        rr_idx = '0;
        pos    = 0;
        for (int k = NUM_PORTS - 1; k >= 1; k--) begin
            pos = int'(grant_q) + k;
            if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
            if (bus.req_port[pos]) begin
                rr_vld = 1'b1;
                rr_idx = PORT_W'(pos);
            end
        end
    end

    always_comb begin
        grant_nxt            = grant_q;
        no_port_nxt          = no_port_q;
        credit_nxt           = credit_q;
        credit_nxt[grant_q]  = owner_cred_nxt;
        if (bus.HMASTLOCKM || next_burst_hold) begin
            grant_nxt = grant_q;
        end else if (no_port_q) begin
            if (lo_vld) begin
                grant_nxt          = lo_idx;
                no_port_nxt        = 1'b0;
                credit_nxt[lo_idx] = w_eff[lo_idx];
            end
        end else if (bus.req_port[grant_q] && owner_cred_nxt != '0) begin
            grant_nxt = grant_q;
        end else if (rr_vld) begin
            grant_nxt          = rr_idx;
            credit_nxt[rr_idx] = w_eff[rr_idx];
        end else if (bus.HSELM) begin
            credit_nxt[grant_q] = w_eff[grant_q];
        end else begin
            no_port_nxt = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q        <= '0;
            no_port_q      <= 1'b1;
            grant_change_q <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) credit_q[i] <= '0;
        end else if (bus.HREADYM) begin
            grant_q        <= grant_nxt;
            no_port_q      <= no_port_nxt;
            grant_change_q <= (grant_nxt != grant_q) || (no_port_nxt != no_port_q);
            credit_q       <= credit_nxt;
        end
    end

    assign bus.addr_in_port = grant_q;
    assign bus.no_port      = no_port_q;
    assign bus.grant_change = grant_change_q;

endmodule
